lift_sensor_conditioner: RTL and testbench
==========================================

# lift_sensor_conditioner

Upstream front end of the lift occupancy counter. It turns the two raw, asynchronous, bouncy door-beam sensor levels (entry, exit) into clean single-cycle entry/exit pulses that drive the up/down counter's `SI`/`SO` inputs. It cancels simultaneous entry+exit events and suppresses entries when the counter reports `Full` and exits when it reports `Empty`. Rejected events are counted for diagnostics.

## Interface
- `DEBOUNCE_CYCLES`, default 3: consecutive stable synchronized samples required to accept a press or a release; legal range 1–15.
- `STUCK_CYCLES`, default 1000: cycles of continuous assertion before a channel is flagged stuck (used only with the macro).
- `REJ_W`, default 8: width of the reject counter.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `SI_RAW` input 1: raw entry beam, asynchronous, active-high.
- `SO_RAW` input 1: raw exit beam, asynchronous, active-high.
- `FULL` input 1: `Full` from the occupancy counter.
- `EMPTY` input 1: `Empty` from the occupancy counter.
- `SI` output 1: one-cycle entry pulse to the counter.
- `SO` output 1: one-cycle exit pulse to the counter.
- `PASS_P` output 1: one-cycle pulse on a cancelled simultaneous entry+exit.
- `REJECT_P` output 1: one-cycle pulse when an event is dropped due to `FULL` or `EMPTY`.
- `REJ_CNT` output `REJ_W`: saturating count of rejected events.
- `STUCK` output 2: {exit, entry} stuck flags (macro only; otherwise tied to 0).

## Operation
- Each raw input passes through a 2-flop synchronizer, then a per-channel debounce FSM.
- FSM states:
  - IDLE: sync=1 → ARMING with cnt=1.
  - ARMING: sync=1 → cnt++; on reaching DEBOUNCE_CYCLES → HELD and raise `qual` for one cycle. sync=0 → IDLE.
  - HELD: sync=0 → RELEASING with cnt=1.
  - RELEASING: sync=0 → cnt++; on reaching DEBOUNCE_CYCLES → IDLE. sync=1 → HELD.
  - With DEBOUNCE_CYCLES=1, IDLE→HELD and HELD→IDLE happen directly.
- Exactly one `qual` per accepted press. A new press is accepted only after a full release.
- Output arbitration, in the cycle after `qual` is evaluated:
  - Both qual: `SI`=`SO`=0, `PASS_P`=1; no reject, regardless of `FULL`/`EMPTY`.
  - Entry qual with `FULL`=1: `SI`=0, `REJECT_P`=1.
  - Exit qual with `EMPTY`=1: `SO`=0, `REJECT_P`=1.
  - Otherwise the qualified channel pulses `SI` or `SO`.
- `REJ_CNT` increments on each `REJECT_P` and saturates at 2^REJ_W−1. Only reset clears it.
- `FULL`/`EMPTY` are sampled in the same cycle as `qual`; they are assumed synchronous to `CLK`.

## Timing
- Reset (async assert, released synchronously by the integrator): all FSMs IDLE; synchronizers 0; `SI`, `SO`, `PASS_P`, `REJECT_P` = 0; `REJ_CNT` = 0; `STUCK` = 0.
- Latency: raw rising edge captured at edge k, held stable → output pulse high from edge k+DEBOUNCE_CYCLES+2 for exactly one cycle.
- A raw pulse shorter than DEBOUNCE_CYCLES clock periods produces no output.
- Releases shorter than DEBOUNCE_CYCLES do not retrigger.
- Qual events one cycle apart are handled as two separate events; only same-cycle qual events cancel.
- Reset asserted mid-debounce discards the pending event; no output after release.
- Pulses are never wider than one cycle. `SI` and `SO` are never high in the same cycle.

## Configuration
- `LIFT_COND_STUCK_EN` defined:
  - Each channel has a counter that runs while the FSM is HELD.
  - When the counter reaches STUCK_CYCLES, the channel's `STUCK` bit sets.
  - The bit clears when the FSM returns to IDLE.
  - While stuck, the channel cannot produce pulses.
- `LIFT_COND_STUCK_EN` undefined: no stuck logic exists and `STUCK` = 2'b00.

## Structure
- Shared package `lift_pkg` holds:
  - debounce state enum (IDLE, ARMING, HELD, RELEASING);
  - default DEBOUNCE_CYCLES, STUCK_CYCLES and REJ_W constants.
- Sub-module `lift_debounce` contains the synchronizer, FSM and optional stuck counter, and outputs `qual` and `stuck`. It is instantiated twice, for entry and exit.
- Arbitration, reject gating and `REJ_CNT` live in the top module.

## Test plan
- Reset, then `SI_RAW` high for 5 cycles (DEBOUNCE_CYCLES=3) → one `SI` pulse 5 edges after capture; `SO`=0; `REJ_CNT`=0.
- `SI_RAW` glitch of 2 cycles, then a 1-cycle low dip inside a 6-cycle press → no pulse for the glitch; exactly one `SI` pulse for the press.
- `SI_RAW` and `SO_RAW` rise together and each is held 5 cycles → `PASS_P`=1 for one cycle; `SI`=`SO`=0.
- `FULL`=1, three entry presses → no `SI`; three `REJECT_P` pulses; `REJ_CNT`=3. Then `EMPTY`=1 with one exit press → `REJ_CNT`=4.
- `RST_N` driven low 2 cycles into a press → no pulse; outputs 0; after release a fresh press yields one pulse.
- With `LIFT_COND_STUCK_EN` and STUCK_CYCLES=20, `SO_RAW` held 30 cycles → one `SO` pulse; `STUCK`=2'b10 from cycle 20 of HELD; `STUCK` clears after the release debounce.

Source files
------------

// File: rtl/lift_pkg.sv
// lift_pkg
// Shared definitions for the lift sensor conditioner:
//   - deb_state_t : per-channel debounce FSM state
//   - DEF_DEBOUNCE_CYCLES, DEF_STUCK_CYCLES, DEF_REJ_W : parameter defaults
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } deb_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 3;
    localparam int DEF_STUCK_CYCLES    = 1000;
    localparam int DEF_REJ_W           = 8;

endpackage

// File: rtl/lift_debounce.sv
// lift_debounce
// One door-beam channel: 2-flop synchronizer followed by a debounce FSM that
// emits a single-cycle qual pulse per accepted press. A new press is only
// accepted after a fully debounced release.
// Optional stuck detection is built when LIFT_COND_STUCK_EN is defined.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   raw         : asynchronous raw beam level (active-high)
//   qual        : one-cycle pulse when a press is accepted (registered)
//   stuck       : channel held longer than STUCK_CYCLES (0 without the macro)
//   state_dbg   : current debounce state, for observation
module lift_debounce
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw,
    output logic       qual,
    output logic       stuck,
    output logic [1:0] state_dbg
);

    // Counter value that, when already reached, makes the current sample the
    // DEBOUNCE_CYCLES-th consecutive one.
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1, sync2;
    deb_state_t state;
    logic [3:0] cnt;
    logic       qual_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            state  <= IDLE;
            cnt    <= 4'd0;
            qual_r <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            qual_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state  <= HELD;
                            qual_r <= 1'b1;
                        end else begin
                            state <= ARMING;
                            cnt   <= 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!sync2) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state  <= HELD;
                        qual_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (!sync2) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= IDLE;
                        end else begin
                            state <= RELEASING;
                            cnt   <= 4'd1;
                        end
                    end
                end
                RELEASING: begin
                    if (sync2) begin
                        state <= HELD;
                    end else if (cnt == DEB_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

`ifdef LIFT_COND_STUCK_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    logic [SW-1:0] stuck_cnt;
    logic          stuck_r;

    // Counts HELD cycles; a short release dip (RELEASING) pauses rather than
    // restarts the count, since the beam never really cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_cnt <= '0;
            stuck_r   <= 1'b0;
        end else if (state == IDLE) begin
            stuck_cnt <= '0;
            stuck_r   <= 1'b0;
        end else if (state == HELD && !stuck_r) begin
            if (stuck_cnt == SW'(STUCK_CYCLES - 1)) begin
                stuck_r <= 1'b1;
            end else begin
                stuck_cnt <= stuck_cnt + SW'(1);
            end
        end
    end

    assign stuck = stuck_r;
    assign qual  = qual_r & ~stuck_r;
`else
    assign stuck = 1'b0;
    assign qual  = qual_r;
`endif

endmodule

// File: rtl/lift_sensor_conditioner.sv
// lift_sensor_conditioner
// Front end of the lift occupancy counter: conditions the raw entry/exit beam
// levels into single-cycle SI/SO pulses, cancels simultaneous entry+exit,
// drops entries while FULL and exits while EMPTY, and counts the drops.
// Optional stuck detection: define LIFT_COND_STUCK_EN.
// Ports:
//   CLK, RST_N     : clock, asynchronous active-low reset
//   SI_RAW, SO_RAW : raw entry / exit beams (asynchronous, active-high)
//   FULL, EMPTY    : occupancy counter status (synchronous to CLK)
//   SI, SO         : one-cycle entry / exit pulses to the counter
//   PASS_P         : one-cycle pulse on a cancelled simultaneous entry+exit
//   REJECT_P       : one-cycle pulse when an event is dropped by FULL/EMPTY
//   REJ_CNT        : saturating reject count
//   STUCK          : {exit, entry} stuck flags (0 without the macro)
//   DBG_STATE      : {exit, entry} debounce FSM states, for observation
module lift_sensor_conditioner
    import lift_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES,
    parameter int REJ_W           = DEF_REJ_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SI_RAW,
    input  logic             SO_RAW,
    input  logic             FULL,
    input  logic             EMPTY,
    output logic             SI,
    output logic             SO,
    output logic             PASS_P,
    output logic             REJECT_P,
    output logic [REJ_W-1:0] REJ_CNT,
    output logic [1:0]       STUCK,
    output logic [3:0]       DBG_STATE
);

    logic       qual_in, qual_out;
    logic       stuck_in, stuck_out;
    logic [1:0] st_in, st_out;

    lift_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_entry (
        .clk      (CLK),
        .rst_n    (RST_N),
        .raw      (SI_RAW),
        .qual     (qual_in),
        .stuck    (stuck_in),
        .state_dbg(st_in)
    );

    lift_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .STUCK_CYCLES   (STUCK_CYCLES)
    ) u_exit (
        .clk      (CLK),
        .rst_n    (RST_N),
        .raw      (SO_RAW),
        .qual     (qual_out),
        .stuck    (stuck_out),
        .state_dbg(st_out)
    );

    // Same-cycle quals cancel and are never treated as a reject.
    logic both_q, entry_only, exit_only, reject_now;

    assign both_q     = qual_in & qual_out;
    assign entry_only = qual_in & ~qual_out;
    assign exit_only  = qual_out & ~qual_in;
    assign reject_now = (entry_only & FULL) | (exit_only & EMPTY);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SI       <= 1'b0;
            SO       <= 1'b0;
            PASS_P   <= 1'b0;
            REJECT_P <= 1'b0;
            REJ_CNT  <= '0;
        end else begin
            SI       <= entry_only & ~FULL;
            SO       <= exit_only & ~EMPTY;
            PASS_P   <= both_q;
            REJECT_P <= reject_now;
            if (reject_now && (REJ_CNT != {REJ_W{1'b1}})) begin
                REJ_CNT <= REJ_CNT + REJ_W'(1);
            end
        end
    end

    assign STUCK     = {stuck_out, stuck_in};
    assign DBG_STATE = {st_out, st_in};

endmodule

// File: tb/tb_lift_sensor_conditioner.sv
module tb_lift_sensor_conditioner;

    localparam int D  = 3;
    localparam int SC = 20;
    localparam int RW = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SI_RAW = 1'b0;
    logic          SO_RAW = 1'b0;
    logic          FULL = 1'b0;
    logic          EMPTY = 1'b0;
    logic          SI, SO, PASS_P, REJECT_P;
    logic [RW-1:0] REJ_CNT;
    logic [1:0]    STUCK;
    logic [3:0]    DBG_STATE;

    lift_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .STUCK_CYCLES   (SC),
        .REJ_W          (RW)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SI_RAW   (SI_RAW),
        .SO_RAW   (SO_RAW),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .SI       (SI),
        .SO       (SO),
        .PASS_P   (PASS_P),
        .REJECT_P (REJECT_P),
        .REJ_CNT  (REJ_CNT),
        .STUCK    (STUCK),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard counters ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A channel's debounced level flips once D consecutive synchronized samples
    // disagree with it; a 0->1 flip is an accepted press. The synchronized
    // sample seen at an edge is the raw level captured two edges earlier.
    bit hist_si[$];
    bit hist_so[$];
    bit m_stable[2];
    int m_run[2];
    bit m_qual[2];
    int m_rej;
    bit e_si, e_so, e_pass, e_rej;

    function automatic void model_reset();
        hist_si.delete();
        hist_so.delete();
        for (int c = 0; c < 2; c++) begin
            m_stable[c] = 1'b0;
            m_run[c]    = 0;
            m_qual[c]   = 1'b0;
        end
        m_rej  = 0;
        e_si   = 1'b0;
        e_so   = 1'b0;
        e_pass = 1'b0;
        e_rej  = 1'b0;
    endfunction

    function automatic void model_edge(bit si, bit so, bit full, bit empty);
        bit samp[2];
        bit qn[2];
        e_pass = m_qual[0] && m_qual[1];
        e_si   = m_qual[0] && !m_qual[1] && !full;
        e_so   = m_qual[1] && !m_qual[0] && !empty;
        e_rej  = (m_qual[0] && !m_qual[1] && full) || (m_qual[1] && !m_qual[0] && empty);
        if (e_rej && m_rej < (1 << RW) - 1) m_rej++;
        hist_si.push_back(si);
        hist_so.push_back(so);
        samp[0] = (hist_si.size() >= 3) ? hist_si[hist_si.size() - 3] : 1'b0;
        samp[1] = (hist_so.size() >= 3) ? hist_so[hist_so.size() - 3] : 1'b0;
        for (int c = 0; c < 2; c++) begin
            qn[c] = 1'b0;
            if (samp[c] != m_stable[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_stable[c] = samp[c];
                    m_run[c]    = 0;
                    qn[c]       = samp[c];
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_qual = qn;
    endfunction

    // ---------------- observed pulse counts ----------------
    int n_si, n_so, n_pass, n_rej, tick_no, first_si;

    function automatic void clear_counts();
        n_si = 0; n_so = 0; n_pass = 0; n_rej = 0; tick_no = 0; first_si = -1;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge: drives inputs, lets one rising edge pass, then
    // compares all pulse outputs against the model on the next negedge.
    task automatic tick(input bit si, input bit so, input bit full, input bit empty);
        SI_RAW = si;
        SO_RAW = so;
        FULL   = full;
        EMPTY  = empty;
        @(posedge CLK);
        model_edge(si, so, full, empty);
        @(negedge CLK);
        check("cycle_outputs", {24'd0, SI, SO, PASS_P, REJECT_P, REJ_CNT},
              {24'd0, e_si, e_so, e_pass, e_rej, 4'(m_rej)});
`ifndef LIFT_COND_STUCK_EN
        check("stuck_tied_low", {30'd0, STUCK}, 32'd0);
`endif
        if (SI === 1'b1) begin
            n_si++;
            if (first_si < 0) first_si = tick_no;
        end
        if (SO === 1'b1) n_so++;
        if (PASS_P === 1'b1) n_pass++;
        if (REJECT_P === 1'b1) n_rej++;
        tick_no++;
    endtask

    task automatic press(input bit ch_exit, input int len, input bit full, input bit empty);
        for (int i = 0; i < len; i++) tick(!ch_exit, ch_exit, full, empty);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, full, empty);
    endtask

    task automatic do_reset();
        RST_N  = 1'b0;
        SI_RAW = 1'b0;
        SO_RAW = 1'b0;
        #1;
        check("reset_outputs", {25'd0, SI, SO, PASS_P, REJECT_P, REJ_CNT}, 32'd0);
        check("reset_state", {28'd0, DBG_STATE}, 32'd0);
        repeat (2) @(negedge CLK);
        check("reset_held_outputs", {25'd0, SI, SO, PASS_P, REJECT_P, REJ_CNT}, 32'd0);
        model_reset();
        RST_N = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int si_len;
        int so_off;
        int so_len;
        bit full;
        bit empty;
        int e_si;
        int e_so;
        int e_pass;
        int e_rej;
    } vec_t;

    vec_t vt[12];

    initial begin
        int len;
        int pat[22];
        bit st_seen;

        vt[0]  = '{5, 0, 0, 1'b0, 1'b0, 1, 0, 0, 0};  // plain entry
        vt[1]  = '{2, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0};  // too short
        vt[2]  = '{3, 0, 0, 1'b0, 1'b0, 1, 0, 0, 0};  // exactly D
        vt[3]  = '{0, 0, 4, 1'b0, 1'b0, 0, 1, 0, 0};  // plain exit
        vt[4]  = '{0, 0, 2, 1'b0, 1'b0, 0, 0, 0, 0};  // short exit
        vt[5]  = '{5, 0, 5, 1'b0, 1'b0, 0, 0, 1, 0};  // simultaneous
        vt[6]  = '{5, 0, 5, 1'b1, 1'b1, 0, 0, 1, 0};  // simultaneous, full+empty
        vt[7]  = '{4, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1};  // entry while full
        vt[8]  = '{0, 0, 4, 1'b0, 1'b1, 0, 0, 0, 1};  // exit while empty
        vt[9]  = '{5, 1, 5, 1'b0, 1'b0, 1, 1, 0, 0};  // quals one cycle apart
        vt[10] = '{5, 0, 1, 1'b0, 1'b0, 1, 0, 0, 0};  // exit glitch beside entry
        vt[11] = '{4, 0, 0, 1'b0, 1'b1, 1, 0, 0, 0};  // empty does not block entry

        // reset values
        model_reset();
        repeat (2) @(negedge CLK);
        check("reset_outputs", {25'd0, SI, SO, PASS_P, REJECT_P, REJ_CNT}, 32'd0);
        check("reset_stuck", {30'd0, STUCK}, 32'd0);
        check("reset_state", {28'd0, DBG_STATE}, 32'd0);
        RST_N = 1'b1;

        // latency: capture at tick 0 edge -> pulse at edge D+2
        clear_counts();
        press(1'b0, 5, 1'b0, 1'b0);
        check("latency_first_si", first_si, D + 2);
        check("latency_si_count", n_si, 1);
        check("latency_so_count", n_so, 0);
        check("latency_rej_cnt", {28'd0, REJ_CNT}, 32'd0);

        // glitch, then a press with a one-cycle dip
        pat = '{1,1,0,0,0,0,0,0, 1,1,1,0,1,1, 0,0,0,0,0,0,0,0};
        clear_counts();
        for (int i = 0; i < 22; i++) begin
            tick(pat[i][0], 1'b0, 1'b0, 1'b0);
            if (i == 7) check("glitch_no_pulse", n_si, 0);
        end
        check("dip_single_si", n_si, 1);

        // table
        for (int v = 0; v < 12; v++) begin
            clear_counts();
            len = (vt[v].si_len > vt[v].so_off + vt[v].so_len) ? vt[v].si_len
                                                               : vt[v].so_off + vt[v].so_len;
            for (int i = 0; i < len + 10; i++) begin
                tick(i < vt[v].si_len, (i >= vt[v].so_off) && (i < vt[v].so_off + vt[v].so_len),
                     vt[v].full, vt[v].empty);
            end
            check($sformatf("vec%0d_si", v), n_si, vt[v].e_si);
            check($sformatf("vec%0d_so", v), n_so, vt[v].e_so);
            check($sformatf("vec%0d_pass", v), n_pass, vt[v].e_pass);
            check($sformatf("vec%0d_rej", v), n_rej, vt[v].e_rej);
        end

        // reset during debounce discards the pending press
        @(negedge CLK);
        clear_counts();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_mid_no_pulse", n_si, 0);
        press(1'b0, 5, 1'b0, 1'b0);
        check("reset_then_fresh_si", n_si, 1);
        check("reset_rej_cnt", {28'd0, REJ_CNT}, 32'd0);

        // rejects while FULL, then EMPTY, then saturation
        clear_counts();
        for (int k = 0; k < 3; k++) press(1'b0, 5, 1'b1, 1'b0);
        check("full_no_si", n_si, 0);
        check("full_rej_pulses", n_rej, 3);
        check("full_rej_cnt", {28'd0, REJ_CNT}, 32'd3);
        press(1'b1, 5, 1'b0, 1'b1);
        check("empty_no_so", n_so, 0);
        check("empty_rej_cnt", {28'd0, REJ_CNT}, 32'd4);
        clear_counts();
        for (int k = 0; k < 12; k++) press(1'b0, 4, 1'b1, 1'b0);
        check("sat_rej_pulses", n_rej, 12);
        check("sat_rej_cnt", {28'd0, REJ_CNT}, 32'd15);

        // randomized level segments against the model
        do_reset();
        for (int s = 0; s < 400; s++) begin
            bit rs, ro, rf, re;
            int rl;
            rs = 1'($urandom_range(0, 1));
            ro = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) == 0);
            rl = $urandom_range(1, 7);
            for (int i = 0; i < rl; i++) tick(rs, ro, rf, re);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LIFT_COND_STUCK_EN
        // exit held 30 cycles: one pulse, stuck flag, cleared after release
        clear_counts();
        st_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            if (STUCK === 2'b10) st_seen = 1'b1;
        end
        check("stuck_flag_set", {31'd0, st_seen}, 32'd1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("stuck_one_so", n_so, 1);
        check("stuck_cleared", {30'd0, STUCK}, 32'd0);
`else
        st_seen = 1'b0;
        clear_counts();
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("long_hold_one_so", n_so, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
